// File: rtl/fp16_pkg.sv
// Shared FP16 constants, field widths, sequencer state encoding and field
// classification helpers for the FP16 multiply-accumulate path.
package fp16_pkg;

  localparam int EXP_W     = 5;
  localparam int MAN_W     = 10;
  localparam int FP16_BIAS = 15;

  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_MUL,
    ST_ADD,
    ST_DONE
  } state_t;

  // Helpers take the 15-bit magnitude; sign never affects classification.
  // A zero exponent is a signed zero, so subnormals are flushed here.
  function automatic logic fp16_is_zero(input logic [14:0] mag);
    return mag[14:10] == 5'd0;
  endfunction

  function automatic logic fp16_is_inf(input logic [14:0] mag);
    return (mag[14:10] == 5'h1F) && (mag[9:0] == 10'd0);
  endfunction

  function automatic logic fp16_is_nan(input logic [14:0] mag);
    return (mag[14:10] == 5'h1F) && (mag[9:0] != 10'd0);
  endfunction

endpackage

// File: rtl/fp16_mac_sequencer_if.sv
// SRAM read port, run enable and accumulator status for the MAC sequencer.
interface fp16_mac_sequencer_if #(
  parameter int ADDR_W = 4
) ();

  logic              en;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       a_data;
  logic [15:0]       b_data;
  logic [15:0]       result;
  logic              busy;
  logic              done;

  modport master (
    input  en,
    input  a_data,
    input  b_data,
    output addr,
    output result,
    output busy,
    output done
  );

  modport slave (
    output en,
    output a_data,
    output b_data,
    input  addr,
    input  result,
    input  busy,
    input  done
  );

endinterface

// File: rtl/fp16_add.sv
// Combinational FP16 adder: flush-to-zero, truncating alignment, LZC
// renormalisation, with a NaN flag for NaN inputs and Inf + (-Inf).
module fp16_add
  import fp16_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] s,
  output logic        nan
);

  function automatic logic [15:0] pack_trunc(input logic sg,
                                             input logic signed [7:0] e,
                                             input logic [MAN_W-1:0] m);
    if (e >= 8'sd31)
      return {sg, FP16_POS_INF[14:0]};
    else if (e <= 8'sd0)
      return {sg, 15'd0};
    else
      return {sg, e[EXP_W-1:0], m};
  endfunction

  function automatic logic [3:0] lzc12(input logic [11:0] v);
    logic [3:0] n;
    n = 4'd12;
    for (int i = 0; i < 12; i++)
      if (v[i]) n = 4'(11 - i);
    return n;
  endfunction

  logic              x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, x_big;
  logic [15:0]       big;
  logic [14:0]       sml;
  logic [EXP_W-1:0]  eb, es, d;
  logic [11:0]       sig_b, sig_s, sum12, diff12, norm;
  logic [3:0]        sh;
  logic signed [7:0] eb_s;
  logic              unused_norm;

  assign x_zero = fp16_is_zero(x[14:0]);
  assign y_zero = fp16_is_zero(y[14:0]);
  assign x_inf  = fp16_is_inf(x[14:0]);
  assign y_inf  = fp16_is_inf(y[14:0]);
  assign x_nan  = fp16_is_nan(x[14:0]);
  assign y_nan  = fp16_is_nan(y[14:0]);

  // Magnitude ordering keeps the subtraction non-negative; the result takes
  // the sign of the larger operand.
  assign x_big = (x[14:0] >= y[14:0]);
  assign big   = x_big ? x : y;
  assign sml   = x_big ? y[14:0] : x[14:0];
  assign eb    = big[14:10];
  assign es    = sml[14:10];
  assign d     = eb - es;
  assign eb_s  = $signed({3'b000, eb});

  assign sig_b       = {2'b01, big[9:0]};
  assign sig_s       = {2'b01, sml[9:0]} >> d;
  assign sum12       = sig_b + sig_s;
  assign diff12      = sig_b - sig_s;
  assign sh          = lzc12(diff12) - 4'd1;
  assign norm        = diff12 << sh;
  assign unused_norm = ^norm[11:10];

  always_comb begin
    nan = x_nan | y_nan | (x_inf & y_inf & (x[15] != y[15]));
    s   = FP16_QNAN;
    if (nan)
      s = FP16_QNAN;
    else if (x_inf)
      s = {x[15], FP16_POS_INF[14:0]};
    else if (y_inf)
      s = {y[15], FP16_POS_INF[14:0]};
    else if (x_zero & y_zero)
      s = {x[15] & y[15], 15'd0};
    else if (x_zero)
      s = y;
    else if (y_zero)
      s = x;
    else if (x[15] == y[15])
      s = sum12[11] ? pack_trunc(big[15], eb_s + 8'sd1, sum12[10:1])
                    : pack_trunc(big[15], eb_s, sum12[9:0]);
    else if (diff12 == 12'd0)
      s = 16'h0000;
    else
      s = pack_trunc(big[15], eb_s - $signed({4'b0000, sh}), norm[9:0]);
  end

endmodule

// File: rtl/fp16_mul.sv
// Combinational FP16 multiplier: flush-to-zero, truncating, with a NaN flag
// for NaN inputs and Inf x 0.
module fp16_mul
  import fp16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] p,
  output logic        nan
);

  localparam logic signed [7:0] BIAS = 8'(FP16_BIAS);

  // Saturate to signed Inf above the exponent range, flush to signed zero below.
  function automatic logic [15:0] pack_trunc(input logic sg,
                                             input logic signed [7:0] e,
                                             input logic [MAN_W-1:0] m);
    if (e >= 8'sd31)
      return {sg, FP16_POS_INF[14:0]};
    else if (e <= 8'sd0)
      return {sg, 15'd0};
    else
      return {sg, e[EXP_W-1:0], m};
  endfunction

  logic                    sp;
  logic [EXP_W-1:0]        ea, eb;
  logic [MAN_W-1:0]        ma, mb;
  logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [21:0]             mprod;
  logic signed [7:0]       e_raw;
  logic                    unused_lsb;

  assign sp = a[15] ^ b[15];
  assign ea = a[14:10];
  assign eb = b[14:10];
  assign ma = a[9:0];
  assign mb = b[9:0];

  assign a_zero = fp16_is_zero(a[14:0]);
  assign b_zero = fp16_is_zero(b[14:0]);
  assign a_inf  = fp16_is_inf(a[14:0]);
  assign b_inf  = fp16_is_inf(b[14:0]);
  assign a_nan  = fp16_is_nan(a[14:0]);
  assign b_nan  = fp16_is_nan(b[14:0]);

  assign mprod      = 22'({1'b1, ma}) * 22'({1'b1, mb});
  assign e_raw      = $signed({3'b000, ea}) + $signed({3'b000, eb}) - BIAS;
  assign unused_lsb = ^mprod[9:0];

  always_comb begin
    nan = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    p   = FP16_QNAN;
    if (nan)
      p = FP16_QNAN;
    else if (a_inf | b_inf)
      p = {sp, FP16_POS_INF[14:0]};
    else if (a_zero | b_zero)
      p = {sp, 15'd0};
    else if (mprod[21])
      p = pack_trunc(sp, e_raw + 8'sd1, mprod[20:11]);
    else
      p = pack_trunc(sp, e_raw, mprod[19:10]);
  end

endmodule

// File: rtl/fp16_mac_sequencer.sv
// Walks SRAM A/B entries 0..DEPTH-1 during the RESULT state and accumulates
// sum(A[i]*B[i]) in FP16, one element per FETCH/MUL/ADD triple.
module fp16_mac_sequencer
  import fp16_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fp16_mac_sequencer_if.master bus
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              last;
  logic              busy, done;

  logic [15:0]       op_a_p0, op_b_p0;
  logic [15:0]       prod_p1;
  logic              prod_nan_p1;
  logic [15:0]       acc_p2;
  logic              nan_flag;

  logic [15:0]       mul_p, add_s;
  logic              mul_nan, add_nan;

  assign last = (idx == ADDR_W'(DEPTH - 1));

  fp16_mul u_mul (
    .a   (op_a_p0),
    .b   (op_b_p0),
    .p   (mul_p),
    .nan (mul_nan)
  );

  fp16_add u_add (
    .x   (acc_p2),
    .y   (prod_p1),
    .s   (add_s),
    .nan (add_nan)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // en is the top-level RESULT state; leaving it aborts from any state.
  always_comb begin
    state_nxt = state;
    if (!bus.en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_FETCH;
        ST_FETCH: state_nxt = ST_MUL;
        ST_MUL:   state_nxt = ST_ADD;
        ST_ADD:   state_nxt = last ? ST_DONE : ST_FETCH;
        ST_DONE:  state_nxt = ST_DONE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_FETCH, ST_MUL, ST_ADD: busy = 1'b1;
      ST_DONE:                  done = 1'b1;
      default:                  ;
    endcase
  end

  // Stage p0: operands captured from the combinational SRAM read in FETCH.
  // Stage p1: product and its special-case flag captured in MUL.
  always_ff @(posedge clk) begin
    if (state == ST_FETCH) begin
      op_a_p0 <= bus.a_data;
      op_b_p0 <= bus.b_data;
    end
    if (state == ST_MUL) begin
      prod_p1     <= mul_p;
      prod_nan_p1 <= mul_nan;
    end
  end

  // Stage p2: accumulator and sticky NaN flag updated in ADD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      acc_p2   <= '0;
      nan_flag <= 1'b0;
    end else if (!bus.en || state == ST_IDLE) begin
      idx      <= '0;
      acc_p2   <= '0;
      nan_flag <= 1'b0;
    end else if (state == ST_ADD) begin
      acc_p2   <= add_s;
      nan_flag <= nan_flag | prod_nan_p1 | add_nan;
      if (!last) idx <= idx + ADDR_W'(1);
    end
  end

  assign bus.addr   = (state == ST_IDLE) ? '0 : idx;
  assign bus.result = nan_flag ? FP16_QNAN : acc_p2;
  assign bus.busy   = busy;
  assign bus.done   = done;

endmodule

// File: tb/tb_fp16_mac_sequencer.sv
// Scoreboard bench for fp16_mac_sequencer: stimulus queues expected partial
// sums and final results, a negedge monitor pops them as the DUT produces them.
module tb_fp16_mac_sequencer;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  addr;
    int          cyc;
  } fin_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  logic [15:0] mem_a [16];
  logic [15:0] mem_b [16];
  logic [15:0] psum_q [$];
  fin_t        fin_q [$];
  logic [15:0] ps [8];

  logic [3:0]  prev_addr = 4'd0;
  logic        prev_done = 1'b0;

  fp16_mac_sequencer_if #(.ADDR_W(4)) bus ();

  fp16_mac_sequencer #(.DEPTH(8), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.a_data = mem_a[bus.addr];
  assign bus.b_data = mem_b[bus.addr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Monitor: an ADD completion shows up as addr advancing while busy, or as
  // done rising on the last element.
  always @(negedge clk) begin
    logic [15:0] e;
    fin_t        f;
    if ((bus.busy && bus.addr != prev_addr) || (bus.done && !prev_done)) begin
      if (psum_q.size() == 0) begin
        chk("unexpected_psum", 32'(bus.result), 32'hDEAD_BEEF);
      end else begin
        e = psum_q.pop_front();
        chk("psum", 32'(bus.result), 32'(e));
      end
    end
    if (bus.done && !prev_done) begin
      if (fin_q.size() == 0) begin
        chk("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        f = fin_q.pop_front();
        chk("final_result", 32'(bus.result), 32'(f.res));
        chk("final_addr", 32'(bus.addr), 32'(f.addr));
        chk("done_edge", 32'(cyc), 32'(f.cyc));
      end
    end
    prev_addr = bus.addr;
    prev_done = bus.done;
  end

  // Called on a negedge: done must rise on the 25th rising edge from here.
  task automatic start_run(input logic [15:0] p [8]);
    fin_t f;
    for (int i = 0; i < 8; i++) psum_q.push_back(p[i]);
    f.res  = p[7];
    f.addr = 4'd7;
    f.cyc  = cyc + 25;
    fin_q.push_back(f);
    bus.en = 1'b1;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done_seen"}, 32'(bus.done), 32'd1);
  endtask

  task automatic hold_and_stop(input string nm, input logic [15:0] exp);
    repeat (2) @(negedge clk);
    chk({nm, "_hold_result"}, 32'(bus.result), 32'(exp));
    chk({nm, "_hold_done"}, 32'(bus.done), 32'd1);
    bus.en = 1'b0;
    @(negedge clk);
    chk({nm, "_idle_done"}, 32'(bus.done), 32'd0);
    chk({nm, "_idle_addr"}, 32'(bus.addr), 32'd0);
  endtask

  task automatic load_ones_twos();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 16'h3C00;
      mem_b[i] = 16'h4000;
    end
    ps = '{16'h4000, 16'h4400, 16'h4600, 16'h4800,
           16'h4900, 16'h4A00, 16'h4B00, 16'h4C00};
  endtask

  initial begin
    int c0;
    bus.en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 16'h0000;
      mem_b[i] = 16'h0000;
    end

    // Asynchronous reset, observed before any clock edge.
    #1 rst = 1'b0;
    #2;
    chk("rst_addr", 32'(bus.addr), 32'd0);
    chk("rst_result", 32'(bus.result), 32'h0000);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1.0 x 2.0 accumulated eight times -> 16.0
    load_ones_twos();
    start_run(ps);
    wait_done("ones_twos");
    hold_and_stop("ones_twos", ps[7]);

    // Alternating +1/-1 products cancel exactly
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 16'h3C00;
      mem_b[i] = i[0] ? 16'hBC00 : 16'h3C00;
    end
    ps = '{16'h3C00, 16'h0000, 16'h3C00, 16'h0000,
           16'h3C00, 16'h0000, 16'h3C00, 16'h0000};
    start_run(ps);
    wait_done("cancel");
    hold_and_stop("cancel", ps[7]);

    // Max finite x 2.0 overflows to +Inf, which then absorbs the zeros
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 16'h0000;
      mem_b[i] = 16'h0000;
    end
    mem_a[0] = 16'h7BFF;
    mem_b[0] = 16'h4000;
    ps = '{16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00,
           16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00};
    start_run(ps);
    wait_done("overflow");
    hold_and_stop("overflow", ps[7]);

    // NaN operand at element 3 makes result read QNaN from that ADD onward
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 16'h3C00;
      mem_b[i] = 16'h3C00;
    end
    mem_a[3] = 16'h7E00;
    ps = '{16'h3C00, 16'h4000, 16'h4200, 16'h7E00,
           16'h7E00, 16'h7E00, 16'h7E00, 16'h7E00};
    start_run(ps);
    wait_done("nan");
    hold_and_stop("nan", ps[7]);

    // Abort after edge 10, then a clean rerun
    load_ones_twos();
    psum_q.push_back(16'h4000);
    psum_q.push_back(16'h4400);
    psum_q.push_back(16'h4600);
    c0 = cyc;
    bus.en = 1'b1;
    while (cyc < c0 + 10) @(negedge clk);
    bus.en = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_result", 32'(bus.result), 32'h0000);
    chk("abort_addr", 32'(bus.addr), 32'd0);
    chk("abort_psums_drained", 32'(psum_q.size()), 32'd0);
    start_run(ps);
    wait_done("rerun");
    hold_and_stop("rerun", ps[7]);

    // Reset asserted while in DONE, then restart on release with en held high
    start_run(ps);
    wait_done("pre_reset");
    #2 rst = 1'b0;
    #1;
    chk("dreset_addr", 32'(bus.addr), 32'd0);
    chk("dreset_result", 32'(bus.result), 32'h0000);
    chk("dreset_busy", 32'(bus.busy), 32'd0);
    chk("dreset_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    start_run(ps);
    rst = 1'b1;
    wait_done("post_reset");
    hold_and_stop("post_reset", ps[7]);

    chk("psum_q_empty", 32'(psum_q.size()), 32'd0);
    chk("fin_q_empty", 32'(fin_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/fp16_mac_sequencer.md
# fp16_mac_sequencer

Walks the two operand SRAMs (A and B) entry by entry, reads each FP16 pair, and accumulates the sum of products A[i]×B[i] in IEEE-754 half precision. Sits directly downstream of the operand-entry SRAMs and upstream of the hex display path. It is enabled by the top-level RESULT state and drives the shared SRAM address during that state.

## Interface
- DEPTH, 8, number of A/B pairs accumulated (addresses 0..DEPTH-1)
- ADDR_W, 4, SRAM address width
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  level enable; high = run/hold result, low = return to IDLE and clear
- addr  out  ADDR_W  SRAM read address (A and B share it)
- a_data  in  16  FP16 operand from SRAM A (combinational read of addr)
- b_data  in  16  FP16 operand from SRAM B
- result  out  16  FP16 accumulator value
- busy  out  1  high in FETCH/MUL/ADD
- done  out  1  high in DONE

## Operation
- FSM states: IDLE, FETCH, MUL, ADD, DONE.
- IDLE: acc=0x0000, idx=0, nan_flag=0. Goes to FETCH on the first edge with en=1.
- FETCH: addr=idx. On the edge, registers a_data and b_data into op_a and op_b. Goes to MUL.
- MUL: on the edge, registers prod = op_a×op_b. Goes to ADD.
- ADD: on the edge, acc = acc+prod. If idx==DEPTH-1, goes to DONE; otherwise idx++ and goes to FETCH.
- DONE: holds acc, stays while en=1.
- en=0 in any state: next edge goes to IDLE, clears acc, idx and nan_flag.
- addr = idx in every state (0 in IDLE/DONE-reset paths; DEPTH-1 held in DONE).
- FP16 format rules:
  - exp=0 is treated as signed zero; subnormals are flushed, both on input and on output.
  - Rounding is truncation toward zero, for both multiply and add.
- Multiply:
  - sign = sa^sb, exp = ea+eb-15, mantissa = 11×11 → 22 bits.
  - If bit21 is set, shift right 1 and exp+1.
  - Keep the 10 bits below the leading one.
  - exp≥31 gives signed Inf (s,0x7C00). exp≤0 gives signed zero.
- Add:
  - Align the smaller magnitude by right-shifting it by the exponent difference; a difference >11 contributes zero.
  - Add or subtract the 12-bit magnitudes and renormalize with a leading-zero count.
  - Exact cancellation gives +0 (0x0000).
  - Overflow gives signed Inf; underflow gives signed zero.
- Specials:
  - Any input with exp=31 and mantissa≠0 (NaN) sets nan_flag.
  - Inf×0 sets nan_flag.
  - Inf+(−Inf) sets nan_flag.
  - Inf+finite gives Inf of the same sign.
  - While nan_flag=1, result=0x7E00 regardless of acc.
- Input Inf with a nonzero finite operand multiplies to signed Inf.

## Timing
- Reset values: addr=0, result=0x0000, busy=0, done=0, FSM=IDLE.
- Each element takes 3 cycles (FETCH, MUL, ADD).
- With DEPTH=8, done rises on the 25th rising edge after en is first sampled high (1 cycle IDLE→FETCH plus 24).
- result updates only at the end of ADD. Intermediate partial sums are visible on result.
- The SRAM read is combinational. a_data and b_data must be stable within the FETCH cycle; addr changes only on edges.
- en=0 mid-run aborts: the next edge gives busy=0, result=0, addr=0. Re-asserting en restarts from idx 0.
- rst low at any time forces the reset values asynchronously. Release is synchronous to the next edge.

## Structure
- Shared package fp16_pkg holds:
  - constants FP16_POS_INF=0x7C00, FP16_QNAN=0x7E00, FP16_BIAS=15;
  - field widths (EXP_W=5, MAN_W=10);
  - the state enum.
- The top module maps en to the RESULT state. The top module also owns the addr mux into the SRAMs.
- Sub-modules:
  - fp16_mul: combinational, with a special-case output.
  - fp16_add: combinational, with a special-case output.
- The sequencer registers their outputs.

## Test plan
- All A=0x3C00 (1.0), all B=0x4000 (2.0), en high → done at edge 25, result=0x4C00 (16.0), addr=7.
- A all 0x3C00; B alternating 0x3C00/0xBC00 → final result=0x0000. Partial sums read 0x3C00, 0x0000, … after each ADD.
- A[0]=0x7BFF, B[0]=0x4000, all other entries 0x0000 → product overflow, final result=0x7C00.
- A[3]=0x7E00, all others 1.0×1.0 → result=0x7E00 from the ADD of element 3 through DONE.
- Drop en at edge 10 (mid element 3) → next edge busy=0, result=0, addr=0. Re-raise en → clean rerun gives 0x4C00 with the first test's data.
- Pull rst low while in DONE → outputs immediately 0/0x0000/0/0. After release with en high, run restarts from addr 0.
